// File: rtl/alu_operand_stage_if.sv
// Bundles the decode-side, bypass-source and EX-side signals of alu_operand_stage.
// slave: the operand stage itself; master: whoever drives ID/MEM/WB and consumes EX.
interface alu_operand_stage_if #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
);
  logic            id_valid;
  logic [RA_W-1:0] id_rs1_addr;
  logic [RA_W-1:0] id_rs2_addr;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [XLEN-1:0] id_imm;
  logic [XLEN-1:0] id_pc;
  logic [3:0]      id_alu_sel;
  logic            id_src1_pc;
  logic            id_src2_imm;
  logic [RA_W-1:0] id_rd_addr;
  logic            id_reg_write;
  logic            id_mem_read;
  logic            flush;

  logic [RA_W-1:0] mem_rd_addr;
  logic            mem_reg_write;
  logic [XLEN-1:0] mem_result;
  logic [RA_W-1:0] wb_rd_addr;
  logic            wb_reg_write;
  logic [XLEN-1:0] wb_result;

  logic            hazard_stall;
  logic            ex_valid;
  logic [XLEN-1:0] ex_i_1;
  logic [XLEN-1:0] ex_i_2;
  logic [3:0]      ex_alu_sel;
  logic [XLEN-1:0] ex_store_data;
  logic [RA_W-1:0] ex_rd_addr;
  logic            ex_reg_write;
  logic            ex_mem_read;

  modport slave (
    input  id_valid, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data, id_imm, id_pc,
           id_alu_sel, id_src1_pc, id_src2_imm, id_rd_addr, id_reg_write, id_mem_read, flush,
           mem_rd_addr, mem_reg_write, mem_result, wb_rd_addr, wb_reg_write, wb_result,
    output hazard_stall, ex_valid, ex_i_1, ex_i_2, ex_alu_sel, ex_store_data,
           ex_rd_addr, ex_reg_write, ex_mem_read
  );

  modport master (
    output id_valid, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data, id_imm, id_pc,
           id_alu_sel, id_src1_pc, id_src2_imm, id_rd_addr, id_reg_write, id_mem_read, flush,
           mem_rd_addr, mem_reg_write, mem_result, wb_rd_addr, wb_reg_write, wb_result,
    input  hazard_stall, ex_valid, ex_i_1, ex_i_2, ex_alu_sel, ex_store_data,
           ex_rd_addr, ex_reg_write, ex_mem_read
  );
endinterface

// File: rtl/alu_operand_stage.sv
// ID/EX register with operand bypass from MEM/WB and load-use stall generation.
// Macro ALU_OPERAND_STAGE_FWD_EN enables the bypass muxes; without it hazards are resolved by stalling.
module alu_operand_stage #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input logic             clk,
  input logic             rst,
  alu_operand_stage_if.slave bus
);

  logic            valid_q, valid_d;
  logic            reg_write_q, reg_write_d;
  logic            mem_read_q, mem_read_d;
  logic            src1_pc_q, src1_pc_d;
  logic            src2_imm_q, src2_imm_d;
  logic [3:0]      alu_sel_q, alu_sel_d;
  logic [RA_W-1:0] rd_addr_q, rd_addr_d;
  logic [RA_W-1:0] rs1_addr_q, rs1_addr_d;
  logic [RA_W-1:0] rs2_addr_q, rs2_addr_d;
  logic [XLEN-1:0] rs1_data_q, rs1_data_d;
  logic [XLEN-1:0] rs2_data_q, rs2_data_d;
  logic [XLEN-1:0] imm_q, imm_d;
  logic [XLEN-1:0] pc_q, pc_d;

  logic            ex_hit;
  logic            stall_raw;
  logic            stall;
  logic            bubble;
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;

  // Dependency of the decode instruction on what EX (and, without bypass, MEM) will write.
  always_comb begin
    ex_hit = (rd_addr_q != '0) &&
             ((rd_addr_q == bus.id_rs1_addr) || (rd_addr_q == bus.id_rs2_addr));
`ifdef ALU_OPERAND_STAGE_FWD_EN
    stall_raw = bus.id_valid & valid_q & mem_read_q & ex_hit;
`else
    stall_raw = bus.id_valid &
                ((valid_q & reg_write_q & ex_hit) |
                 (bus.mem_reg_write && (bus.mem_rd_addr != '0) &&
                  ((bus.mem_rd_addr == bus.id_rs1_addr) || (bus.mem_rd_addr == bus.id_rs2_addr))));
`endif
    // Reset gating keeps the stall low even when external MEM inputs match during reset.
    stall = stall_raw & ~bus.flush & ~rst;
  end

  always_comb begin
    bubble      = bus.flush | stall;
    valid_d     = bus.id_valid & ~bubble;
    reg_write_d = bus.id_reg_write & ~bubble;
    mem_read_d  = bus.id_mem_read & ~bubble;
    src1_pc_d   = bus.id_src1_pc;
    src2_imm_d  = bus.id_src2_imm;
    alu_sel_d   = bus.id_alu_sel;
    rd_addr_d   = bus.id_rd_addr;
    rs1_addr_d  = bus.id_rs1_addr;
    rs2_addr_d  = bus.id_rs2_addr;
    imm_d       = bus.id_imm;
    pc_d        = bus.id_pc;
    // Register file is written at the same edge we read it, so take WB's value directly.
    rs1_data_d  = bus.id_rs1_data;
    rs2_data_d  = bus.id_rs2_data;
    if (bus.wb_reg_write && (bus.wb_rd_addr != '0) && (bus.wb_rd_addr == bus.id_rs1_addr))
      rs1_data_d = bus.wb_result;
    if (bus.wb_reg_write && (bus.wb_rd_addr != '0) && (bus.wb_rd_addr == bus.id_rs2_addr))
      rs2_data_d = bus.wb_result;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      src1_pc_q   <= 1'b0;
      src2_imm_q  <= 1'b0;
      alu_sel_q   <= '0;
      rd_addr_q   <= '0;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      pc_q        <= '0;
    end else begin
      valid_q     <= valid_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      src1_pc_q   <= src1_pc_d;
      src2_imm_q  <= src2_imm_d;
      alu_sel_q   <= alu_sel_d;
      rd_addr_q   <= rd_addr_d;
      rs1_addr_q  <= rs1_addr_d;
      rs2_addr_q  <= rs2_addr_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      imm_q       <= imm_d;
      pc_q        <= pc_d;
    end
  end

`ifdef ALU_OPERAND_STAGE_FWD_EN
  // MEM is the younger producer, so it wins over WB; x0 is hard-wired zero and never bypassed.
  always_comb begin
    fwd_rs1 = rs1_data_q;
    if (bus.mem_reg_write && (bus.mem_rd_addr != '0) && (bus.mem_rd_addr == rs1_addr_q))
      fwd_rs1 = bus.mem_result;
    else if (bus.wb_reg_write && (bus.wb_rd_addr != '0) && (bus.wb_rd_addr == rs1_addr_q))
      fwd_rs1 = bus.wb_result;
    fwd_rs2 = rs2_data_q;
    if (bus.mem_reg_write && (bus.mem_rd_addr != '0) && (bus.mem_rd_addr == rs2_addr_q))
      fwd_rs2 = bus.mem_result;
    else if (bus.wb_reg_write && (bus.wb_rd_addr != '0) && (bus.wb_rd_addr == rs2_addr_q))
      fwd_rs2 = bus.wb_result;
  end
`else
  logic unused_fwd_srcs;
  assign unused_fwd_srcs = ^{rs1_addr_q, rs2_addr_q, bus.mem_result};

  always_comb begin
    fwd_rs1 = rs1_data_q;
    fwd_rs2 = rs2_data_q;
  end
`endif

  assign bus.hazard_stall  = stall;
  assign bus.ex_valid      = valid_q;
  assign bus.ex_i_1        = src1_pc_q ? pc_q : fwd_rs1;
  assign bus.ex_i_2        = src2_imm_q ? imm_q : fwd_rs2;
  assign bus.ex_alu_sel    = alu_sel_q;
  assign bus.ex_store_data = fwd_rs2;
  assign bus.ex_rd_addr    = rd_addr_q;
  assign bus.ex_reg_write  = valid_q & reg_write_q;
  assign bus.ex_mem_read   = valid_q & mem_read_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage; expectations follow whichever hazard mode is compiled.
module tb_alu_operand_stage;

`ifdef ALU_OPERAND_STAGE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;

  alu_operand_stage_if #(.XLEN(32), .RA_W(5)) bus ();

  alu_operand_stage #(.XLEN(32), .RA_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.id_valid      = 1'b0;
    bus.id_rs1_addr   = '0;
    bus.id_rs2_addr   = '0;
    bus.id_rs1_data   = '0;
    bus.id_rs2_data   = '0;
    bus.id_imm        = '0;
    bus.id_pc         = '0;
    bus.id_alu_sel    = '0;
    bus.id_src1_pc    = 1'b0;
    bus.id_src2_imm   = 1'b0;
    bus.id_rd_addr    = '0;
    bus.id_reg_write  = 1'b0;
    bus.id_mem_read   = 1'b0;
    bus.flush         = 1'b0;
    bus.mem_rd_addr   = '0;
    bus.mem_reg_write = 1'b0;
    bus.mem_result    = '0;
    bus.wb_rd_addr    = '0;
    bus.wb_reg_write  = 1'b0;
    bus.wb_result     = '0;
  endtask

  task automatic issue_load_rd3();
    idle();
    bus.id_valid     = 1'b1;
    bus.id_rd_addr   = 5'd3;
    bus.id_reg_write = 1'b1;
    bus.id_mem_read  = 1'b1;
    tick();
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst    = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("rel_valid0", {31'd0, bus.ex_valid}, 32'd0);

    // Load-type instruction with PC/imm operands.
    bus.id_valid     = 1'b1;
    bus.id_pc        = 32'h100;
    bus.id_src1_pc   = 1'b1;
    bus.id_imm       = 32'h44;
    bus.id_src2_imm  = 1'b1;
    bus.id_alu_sel   = 4'd5;
    bus.id_rd_addr   = 5'd3;
    bus.id_reg_write = 1'b1;
    bus.id_mem_read  = 1'b1;
    tick();
    chk("cap_valid", {31'd0, bus.ex_valid}, 32'd1);
    chk("cap_i1_pc", bus.ex_i_1, 32'h100);
    chk("cap_i2_imm", bus.ex_i_2, 32'h44);
    chk("cap_alusel", {28'd0, bus.ex_alu_sel}, 32'd5);
    chk("cap_rd", {27'd0, bus.ex_rd_addr}, 32'd3);
    chk("cap_rw", {31'd0, bus.ex_reg_write}, 32'd1);
    chk("cap_mr", {31'd0, bus.ex_mem_read}, 32'd1);
    bus.id_rs1_addr = 5'd3;
    #1 chk("lu_stall_pre_rst", {31'd0, bus.hazard_stall}, 32'd1);

    // Async reset while the load sits in EX.
    rst = 1'b1;
    #1;
    chk("rst_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("rst_stall", {31'd0, bus.hazard_stall}, 32'd0);
    chk("rst_i1", bus.ex_i_1, 32'd0);
    chk("rst_i2", bus.ex_i_2, 32'd0);
    chk("rst_misc", {bus.ex_alu_sel, bus.ex_rd_addr, bus.ex_reg_write, bus.ex_mem_read}, 32'd0);
    chk("rst_store", bus.ex_store_data, 32'd0);
    tick();
    idle();
    rst = 1'b0;
    tick();
    chk("post_rst_valid", {31'd0, bus.ex_valid}, 32'd0);

    // MEM bypass onto rs1.
    bus.id_valid    = 1'b1;
    bus.id_rs1_addr = 5'd5;
    bus.id_rs1_data = 32'hAAAA;
    tick();
    idle();
    bus.mem_rd_addr   = 5'd5;
    bus.mem_reg_write = 1'b1;
    bus.mem_result    = 32'h10;
    #1 chk("mem_fwd_i1", bus.ex_i_1, FWD ? 32'h10 : 32'hAAAA);

    // MEM beats WB on rs2; WB alone when MEM stops writing.
    idle();
    bus.id_valid    = 1'b1;
    bus.id_rs2_addr = 5'd7;
    bus.id_rs2_data = 32'hBBBB;
    tick();
    idle();
    bus.mem_rd_addr   = 5'd7;
    bus.mem_reg_write = 1'b1;
    bus.mem_result    = 32'h11;
    bus.wb_rd_addr    = 5'd7;
    bus.wb_reg_write  = 1'b1;
    bus.wb_result     = 32'h22;
    #1;
    chk("prio_i2", bus.ex_i_2, FWD ? 32'h11 : 32'hBBBB);
    chk("prio_store", bus.ex_store_data, FWD ? 32'h11 : 32'hBBBB);
    bus.mem_reg_write = 1'b0;
    #1 chk("wb_fwd_i2", bus.ex_i_2, FWD ? 32'h22 : 32'hBBBB);

    // x0 is never bypassed.
    idle();
    bus.id_valid = 1'b1;
    tick();
    idle();
    bus.mem_reg_write = 1'b1;
    bus.mem_result    = 32'hFFFF;
    #1 chk("x0_i1", bus.ex_i_1, 32'd0);

    // Non-load dependency: bypassed with forwarding, stalled without.
    idle();
    bus.id_valid     = 1'b1;
    bus.id_rd_addr   = 5'd3;
    bus.id_reg_write = 1'b1;
    tick();
    idle();
    bus.id_valid    = 1'b1;
    bus.id_rs1_addr = 5'd3;
    #1 chk("alu_dep_stall", {31'd0, bus.hazard_stall}, FWD ? 32'd0 : 32'd1);

    // Load-use: lw x3 in EX, add uses x3 as rs2.
    issue_load_rd3();
    bus.id_valid     = 1'b1;
    bus.id_rs1_addr  = 5'd1;
    bus.id_rs2_addr  = 5'd3;
    bus.id_rs2_data  = 32'h999;
    bus.id_rd_addr   = 5'd4;
    bus.id_reg_write = 1'b1;
    bus.id_mem_read  = 1'b0;
    #1 chk("lu_stall1", {31'd0, bus.hazard_stall}, 32'd1);
    tick();
    bus.mem_rd_addr   = 5'd3;
    bus.mem_reg_write = 1'b1;
    bus.mem_result    = 32'hDEAD;
    #1;
    chk("lu_bubble", {31'd0, bus.ex_valid}, 32'd0);
`ifdef ALU_OPERAND_STAGE_FWD_EN
    chk("lu_stall_end", {31'd0, bus.hazard_stall}, 32'd0);
    tick();
    bus.id_valid      = 1'b0;
    bus.mem_reg_write = 1'b0;
    bus.wb_rd_addr    = 5'd3;
    bus.wb_reg_write  = 1'b1;
    bus.wb_result     = 32'h1234;
    #1;
    chk("lu_add_valid", {31'd0, bus.ex_valid}, 32'd1);
    chk("lu_add_i2", bus.ex_i_2, 32'h1234);
`else
    chk("lu_stall2", {31'd0, bus.hazard_stall}, 32'd1);
    tick();
    bus.mem_reg_write = 1'b0;
    bus.wb_rd_addr    = 5'd3;
    bus.wb_reg_write  = 1'b1;
    bus.wb_result     = 32'h1234;
    #1;
    chk("lu_stall_end", {31'd0, bus.hazard_stall}, 32'd0);
    chk("lu_bubble2", {31'd0, bus.ex_valid}, 32'd0);
    tick();
    bus.id_valid     = 1'b0;
    bus.wb_reg_write = 1'b0;
    bus.wb_result    = 32'h0;
    #1;
    chk("lu_add_valid", {31'd0, bus.ex_valid}, 32'd1);
    chk("lu_add_i2", bus.ex_i_2, 32'h1234);
`endif
    chk("lu_add_store", bus.ex_store_data, 32'h1234);

    // Flush overrides a load-use stall.
    issue_load_rd3();
    bus.id_valid    = 1'b1;
    bus.id_rs1_addr = 5'd3;
    bus.flush       = 1'b1;
    #1 chk("flush_nostall", {31'd0, bus.hazard_stall}, 32'd0);
    tick();
    chk("flush_bubble", {31'd0, bus.ex_valid}, 32'd0);
    chk("flush_rw", {31'd0, bus.ex_reg_write}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
